// File: rtl/mul32.sv
// rtl/mul32.sv - 3-stage pipelined WIDTHxWIDTH multiplier, low WIDTH bits of the product.
// Optional MUL_VALID_EN adds in_valid/out_valid tracked in lockstep with the data stages.
module mul32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MUL_VALID_EN
    input  logic             in_valid,
    output logic             out_valid,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] ll_q, ll_d;
    logic [H-1:0]     lh_q, lh_d;
    logic [H-1:0]     hl_q, hl_d;
    logic [WIDTH-1:0] z_q, z_d;

    // Cross terms only contribute their low H bits to the low word; hi*hi never does.
    always_comb begin
        ll_d = {{H{1'b0}}, a_q[H-1:0]} * {{H{1'b0}}, b_q[H-1:0]};
        lh_d = a_q[H-1:0] * b_q[WIDTH-1:H];
        hl_d = a_q[WIDTH-1:H] * b_q[H-1:0];
        z_d  = ll_q + {lh_q + hl_q, {H{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            ll_q <= '0;
            lh_q <= '0;
            hl_q <= '0;
            z_q  <= '0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            ll_q <= ll_d;
            lh_q <= lh_d;
            hl_q <= hl_d;
            z_q  <= z_d;
        end
    end

    assign z = z_q;

`ifdef MUL_VALID_EN
    logic [2:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[1:0], in_valid};
        end
    end

    assign out_valid = vld_q[2];
`endif

endmodule

// File: tb/tb_mul32.sv
// tb/tb_mul32.sv - directed-vector bench for mul32 (covers MUL_VALID_EN when defined).
module tb_mul32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b;
    logic [31:0] z;
`ifdef MUL_VALID_EN
    logic        in_valid;
    logic        out_valid;
`endif

    int n_cmp;
    int n_bad;

    logic [31:0] hist_z [3];
    logic        hist_v [3];

    mul32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUL_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .a         (a),
        .b         (b),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            hist_z[i] = '0;
            hist_v[i] = 1'b0;
        end
    endtask

    // Check the result owed from three steps back, then present the next operand pair.
    task automatic step(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ev, input logic iv);
        @(negedge clk);
        check({tag, " z"}, z, hist_z[2]);
`ifdef MUL_VALID_EN
        check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, hist_v[2]});
        in_valid = iv;
`endif
        hist_z[2] = hist_z[1];
        hist_z[1] = hist_z[0];
        hist_z[0] = ev;
        hist_v[2] = hist_v[1];
        hist_v[1] = hist_v[0];
        hist_v[0] = iv;
        a = av;
        b = bv;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_hist();
        rst_n = 1'b0;
        a = 32'd0;
        b = 32'd0;
`ifdef MUL_VALID_EN
        in_valid = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset z", z, 32'd0);
        rst_n = 1'b1;

        step("single 3*5",    32'd3,          32'd5,          32'd15,         1'b1);
        step("wrap ff*ff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b1);
        step("wrap 2^16sq",   32'd65536,      32'd65536,      32'd0,          1'b1);
        step("large",         32'd123456,     32'd654321,     32'd3470442048, 1'b1);
        step("stream 1*1",    32'd1,          32'd1,          32'd1,          1'b1);
        step("stream 2*3",    32'd2,          32'd3,          32'd6,          1'b1);
        step("stream 7*9",    32'd7,          32'd9,          32'd63,         1'b1);
        step("stream 0*x",    32'd0,          32'd12345,      32'd0,          1'b1);
        step("stream 1e5sq",  32'd100000,     32'd100000,     32'd1410065408, 1'b1);
        step("inflight 1",    32'd11,         32'd13,         32'd143,        1'b1);
        step("inflight 2",    32'h0001_0000,  32'd3,          32'd196608,     1'b1);
        step("inflight 3",    32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1);

        // Asynchronous reset between edges while the last three products are in flight.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset z", z, 32'd0);
`ifdef MUL_VALID_EN
        check("async reset out_valid", {31'd0, out_valid}, 32'd0);
`endif
        @(negedge clk);
        check("held reset z", z, 32'd0);
        clear_hist();
        a = 32'd0;
        b = 32'd0;
`ifdef MUL_VALID_EN
        in_valid = 1'b0;
`endif
        rst_n = 1'b1;

        step("post-reset 0",  32'd0, 32'd0, 32'd0, 1'b0);
        step("post-reset 1",  32'd0, 32'd0, 32'd0, 1'b0);
        step("valid 2*2",     32'd2, 32'd2, 32'd4,  1'b1);
        step("invalid 9*9",   32'd9, 32'd9, 32'd81, 1'b0);
        step("valid 4*4",     32'd4, 32'd4, 32'd16, 1'b1);
        step("drain 0",       32'd0, 32'd0, 32'd0,  1'b0);
        step("drain 1",       32'd0, 32'd0, 32'd0,  1'b0);
        step("drain 2",       32'd0, 32'd0, 32'd0,  1'b0);
        step("drain 3",       32'd0, 32'd0, 32'd0,  1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
